// File: rtl/lcd_bus_rx.sv
// HD44780-style 4-bit bus receiver: assembles nibble pairs into bytes, decodes
// a subset of commands and mirrors character writes into a 32-entry buffer.
module lcd_bus_rx #(
    parameter int TIMEOUT = 4095
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] LCD_FPGA_DB,
    input  logic       LCD_FPGA_E,
    input  logic       LCD_FPGA_RS,
    input  logic       LCD_FPGA_RW,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_rs,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [4:0] cursor,
    output logic       disp_on,
    output logic       two_line,
    output logic       busy,
    output logic       err
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CLEAR} state_t;

    state_t        state;
    logic          e_q;
    logic [3:0]    db_cap;
    logic          rs_cap;
    logic [3:0]    hi_nib;
    logic          hi_rs;
    logic          phase_lo;
    logic [TW-1:0] tcount;
    logic [4:0]    clr_idx;
    logic          inc;
    logic [7:0]    mem [32];

    logic       fall;
    logic [7:0] asm_byte;
    logic       char_wr;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;

    assign fall     = e_q & ~LCD_FPGA_E;
    assign asm_byte = {hi_nib, db_cap};
    assign char_wr  = fall & ~LCD_FPGA_RW & phase_lo & (rs_cap == hi_rs)
                    & rs_cap & (state == ST_IDLE);
    assign busy     = (state == ST_CLEAR);

    // The clear sweep owns the single write port; character writes only happen in IDLE.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        wr_en   = 1'b0;
        wr_addr = cursor;
        wr_data = asm_byte;
        if (state == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_idx;
            wr_data = 8'h20;
        end else if (char_wr) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (RESET) begin
            state      <= ST_INIT;
            e_q        <= 1'b0;
            db_cap     <= 4'h0;
            rs_cap     <= 1'b0;
            hi_nib     <= 4'h0;
            hi_rs      <= 1'b0;
            phase_lo   <= 1'b0;
            tcount     <= '0;
            clr_idx    <= 5'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            byte_rs    <= 1'b0;
            err        <= 1'b0;
            cursor     <= 5'd0;
            inc        <= 1'b1;
            disp_on    <= 1'b0;
            two_line   <= 1'b0;
        end else begin
            e_q        <= LCD_FPGA_E;
            byte_valid <= 1'b0;
            err        <= 1'b0;

            if (LCD_FPGA_E) begin
                db_cap <= LCD_FPGA_DB;
                rs_cap <= LCD_FPGA_RS;
            end

            case (state)
                ST_INIT: begin
                    state   <= ST_CLEAR;
                    clr_idx <= 5'd0;
                end
                ST_CLEAR: begin
                    clr_idx <= clr_idx + 5'd1;
                    if (clr_idx == 5'd31) begin
                        state  <= ST_IDLE;
                        cursor <= 5'd0;
                        inc    <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (fall && LCD_FPGA_RW) begin
                err <= 1'b1;
            end else if (fall && !phase_lo) begin
                hi_nib   <= db_cap;
                hi_rs    <= rs_cap;
                phase_lo <= 1'b1;
                tcount   <= '0;
            end else if (fall) begin
                phase_lo <= 1'b0;
                tcount   <= '0;
                if (rs_cap != hi_rs || state != ST_IDLE) begin
                    err <= 1'b1;
                end else begin
                    byte_valid <= 1'b1;
                    byte_data  <= asm_byte;
                    byte_rs    <= rs_cap;
                    if (rs_cap) begin
                        cursor <= inc ? cursor + 5'd1 : cursor - 5'd1;
                    end else if (asm_byte[7]) begin
                        cursor <= {asm_byte[6], asm_byte[3:0]};
                    end else if (asm_byte[5]) begin
                        two_line <= asm_byte[3];
                    end else if (asm_byte[4]) begin
                        // cursor/display shift: not modelled
                    end else if (asm_byte[3]) begin
                        disp_on <= asm_byte[2];
                    end else if (asm_byte[2]) begin
                        inc <= asm_byte[1];
                    end else if (asm_byte[1]) begin
                        cursor <= 5'd0;
                    end else if (asm_byte[0]) begin
                        state   <= ST_CLEAR;
                        clr_idx <= 5'd0;
                    end
                end
            end else if (phase_lo) begin
                // A stalled low nibble realigns the phase so the next nibble is taken as high.
                if (tcount == T_LAST) begin
                    phase_lo <= 1'b0;
                    tcount   <= '0;
                end else begin
                    tcount <= tcount + TW'(1);
                end
            end
        end
    end

    // NOTE: the character buffer has no reset; the clear sweep initialises it after every reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_char <= mem[rd_addr];
    end

endmodule
